word_accumulator: RTL and testbench
===================================

# word_accumulator

Downstream consumer stage for a single-entry 32-bit FIFO. It dequeues words from the FIFO's `out` side, sums each group of `COUNT` consecutive words, and offers the group sum to the next stage through an enq-style handshake. It sits between a Fifo1 output and any enq-style sink, and contains a two-state FSM, a word counter, an accumulator and a sums-emitted counter.

## Interface

**Parameters**
- `WIDTH`, default 32: data width of input words, accumulator and output sum.
- `COUNT`, default 4: words per group. Legal range 1..255.

**Ports**
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `nRST`, input, 1: reset, asynchronous and active-low.
- `in$first`, input, WIDTH: head word of the upstream FIFO.
- `in$first__RDY`, input, 1: `in$first` is valid.
- `in$deq__RDY`, input, 1: upstream accepts a dequeue.
- `in$deq__ENA`, output, 1: dequeue strobe, combinational.
- `out$enq__ENA`, output, 1: group sum is offered this cycle.
- `out$enq$v`, output, WIDTH: group sum.
- `out$enq__RDY`, input, 1: downstream accepts the enq.
- `sums$count`, output, 16: number of sums transferred since reset. Wraps 0xFFFF→0.

## Operation

**States**
- ACCUM (reset state): collecting words.
- EMIT: holding a completed sum.

**ACCUM**
- `in$deq__ENA = in$first__RDY & in$deq__RDY`. This dequeue is called a *take*.
- On a take:
  - `acc <= acc + in$first`, truncated to WIDTH (wrap-around unless saturation is compiled in).
  - `cnt <= cnt + 1`.
- On a take with `cnt == COUNT-1`:
  - `acc <= acc + in$first`.
  - `cnt <= 0`.
  - state → EMIT.
- No take: all state holds.

**EMIT**
- `in$deq__ENA = 0`. No words are consumed.
- `out$enq__ENA = 1`; `out$enq$v = acc` (registered, stable while held).
- When `out$enq__RDY = 1`:
  - transfer occurs;
  - `acc <= 0`;
  - `sums$count` increments;
  - state → ACCUM.
- `out$enq__RDY` low: hold indefinitely, with `out$enq$v` unchanged.

**Outputs outside EMIT**
- `out$enq__ENA = 0`.
- `out$enq$v = 0`. It is driven from `acc` only in EMIT.

**`COUNT = 1`**
- Every take goes directly to EMIT.
- The emitted sum equals the word taken.

**Reset**
- `nRST` low clears, immediately and regardless of CLK: state = ACCUM, `acc = 0`, `cnt = 0`, `sums$count = 0`.
- While `nRST` is low, `in$deq__ENA = 0` (gated by reset), `out$enq__ENA = 0` and `out$enq$v = 0`.
- A partial group, or a held un-transferred sum, is discarded on reset.

## Timing

- Dequeue is combinational from `in$first__RDY`/`in$deq__RDY` in ACCUM. There is no added latency on the input side.
- **Sum availability:** `out$enq__ENA` rises in the cycle after the COUNT-th take.
- **Peak throughput:** COUNT + 1 cycles per group (COUNT takes plus one EMIT cycle with `out$enq__RDY = 1`).
- Fed from a Fifo1, takes occur at most every other cycle. This stage does not mask that limit.
- **Same-edge behaviour:** a take and a transfer never coincide, because ACCUM and EMIT are exclusive.
- **Sum contents:** the sum reflects exactly the COUNT words taken, in order. No word is lost or duplicated across an EMIT stall.

## Configuration

- Macro: `WORD_ACCUMULATOR_SATURATE_EN`.
- **Defined:** accumulation saturates. If the true sum exceeds 2^WIDTH−1, `acc` holds 2^WIDTH−1 for the rest of the group.
- **Undefined:** accumulation wraps modulo 2^WIDTH.
- The macro has no other effect on the interface or timing.

## Test plan

1. **Basic group.** Reset, then COUNT=4. Present words 1, 2, 3, 4 with `out$enq__RDY = 1`. Required: `out$enq__ENA` pulses one cycle with `out$enq$v = 10`, and `sums$count = 1`.
2. **Backpressure.** Hold `out$enq__RDY = 0` for 5 cycles after a group of 0x10 ×4. Required: `out$enq$v = 0x40` is held and `in$deq__ENA = 0` throughout. Raise RDY → one transfer. The next group 5, 5, 5, 5 yields 20.
3. **Overflow.** Words 0xFFFFFFFF, 2, 0, 0:
   - macro undefined → sum 0x00000001;
   - macro defined → sum 0xFFFFFFFF.
4. **Upstream gaps.** Toggle `in$first__RDY` randomly for words 7, 8, 9, 10. Required: one sum of 34, and `in$deq__ENA` only when both RDYs are high.
5. **Reset mid-group.** After 2 takes (values 100, 200), assert `nRST` low asynchronously between edges. Required: outputs go to 0 immediately. After release, words 1, 1, 1, 1 → sum 4.
6. **COUNT=1 and counter wrap.** With `COUNT = 1`, stream 65537 words of value 3 with `out$enq__RDY = 1`. Required: every sum is 3, and `sums$count` wraps to 1.

Source files
------------

// File: rtl/word_accumulator_if.sv
// word_accumulator_if: bundles the upstream Fifo1 "out" side and the
// downstream enq-style side used by word_accumulator.
// The slave modport is the accumulator's own view. The master modport is the
// view of whatever drives it: the FIFO plus the sink, or a testbench.

interface word_accumulator_if #(
  parameter int WIDTH = 32
);

  // Upstream FIFO head and dequeue handshake
  logic [WIDTH-1:0] in_first;
  logic             in_first__RDY;
  logic             in_deq__RDY;
  logic             in_deq__ENA;

  // Downstream enq handshake carrying the group sum
  logic             out_enq__ENA;
  logic [WIDTH-1:0] out_enq_v;
  logic             out_enq__RDY;

  modport slave (
    input  in_first,
    input  in_first__RDY,
    input  in_deq__RDY,
    output in_deq__ENA,
    output out_enq__ENA,
    output out_enq_v,
    input  out_enq__RDY
  );

  modport master (
    output in_first,
    output in_first__RDY,
    output in_deq__RDY,
    input  in_deq__ENA,
    input  out_enq__ENA,
    input  out_enq_v,
    output out_enq__RDY
  );

endinterface

// File: rtl/word_accumulator.sv
// word_accumulator: dequeues words from a single-entry FIFO and sums each
// group of COUNT consecutive words. It then offers the group sum to the next
// stage through an enq-style handshake and counts every sum transferred.
//
// Optional feature:
//   WORD_ACCUMULATOR_SATURATE_EN
//     Defined:   the accumulator clamps at 2^WIDTH-1 for the rest of the group.
//     Undefined: the accumulator wraps modulo 2^WIDTH.
//
// Legal COUNT range is 1..255, which is why the word counter is 8 bits wide.

module word_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  word_accumulator_if.slave  bus,
  output logic [15:0]        sums_count
);

  typedef enum logic {
    ACCUM = 1'b0,  // collecting words
    EMIT  = 1'b1   // holding a completed sum for the sink
  } state_t;

  // Counter value of the last word in a group
  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      sums_q, sums_d;
  logic             enq_ena_q, enq_ena_d;
  logic [WIDTH-1:0] enq_v_q, enq_v_d;

  logic             take;
  logic             transfer;
  logic [WIDTH-1:0] acc_plus;

  // A take consumes the FIFO head. A transfer hands the held sum downstream.
  // The two can never happen in the same cycle because they belong to
  // different states.
  assign take     = (state_q == ACCUM) && bus.in_first__RDY && bus.in_deq__RDY;
  assign transfer = (state_q == EMIT) && bus.out_enq__RDY;

`ifdef WORD_ACCUMULATOR_SATURATE_EN
  logic [WIDTH:0] sum_wide;

  // Saturating adder: a carry out means the true sum no longer fits, so clamp.
  // Once clamped, any later non-zero word carries again and the value stays put.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, bus.in_first};
    acc_plus = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
  end
`else
  // Wrapping adder: the sum is truncated to WIDTH bits
  always_comb begin
    acc_plus = acc_q + bus.in_first;
  end
`endif

  // Next-state and registered-output logic for the ACCUM/EMIT FSM
  always_comb begin
    // NOTE: every variable written here gets a hold default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sums_d    = sums_q;
    enq_ena_d = enq_ena_q;
    enq_v_d   = enq_v_q;

    case (state_q)
      ACCUM: begin
        if (take) begin
          acc_d = acc_plus;
          if (cnt_q == LAST_IDX) begin
            // Last word of the group: present the completed sum next cycle
            cnt_d     = '0;
            state_d   = EMIT;
            enq_ena_d = 1'b1;
            enq_v_d   = acc_plus;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      EMIT: begin
        // With RDY low the sum simply stays held, unchanged
        if (transfer) begin
          acc_d     = '0;
          sums_d    = sums_q + 16'd1;
          state_d   = ACCUM;
          enq_ena_d = 1'b0;
          enq_v_d   = '0;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers. The asynchronous reset discards any partial or held sum.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sums_q    <= '0;
      enq_ena_q <= 1'b0;
      enq_v_q   <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample the pre-edge values, so the order of these lines does not matter.
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sums_q    <= sums_d;
      enq_ena_q <= enq_ena_d;
      enq_v_q   <= enq_v_d;
    end
  end

  // The dequeue strobe is combinational so no input latency is added. It is
  // gated by reset because state_q already reads ACCUM while nRST is low.
  assign bus.in_deq__ENA  = take && nRST;
  assign bus.out_enq__ENA = enq_ena_q;
  assign bus.out_enq_v    = enq_v_q;
  assign sums_count       = sums_q;

endmodule

// File: tb/tb_word_accumulator.sv
// tb_word_accumulator: directed and random stimulus for two word_accumulator
// instances, u0 with COUNT=4 and u1 with COUNT=1. Expected values come from a
// reference model that keeps the unbounded arithmetic sum of the words taken
// in each group. The model applies wrap or saturation only when the group
// completes.

module tb_word_accumulator;

  localparam int W  = 32;
  localparam int C0 = 4;
  localparam int C1 = 1;

`ifdef WORD_ACCUMULATOR_SATURATE_EN
  localparam logic [W-1:0] OVF_SUM = 32'hFFFF_FFFF;
`else
  localparam logic [W-1:0] OVF_SUM = 32'h0000_0001;
`endif

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  always #5 CLK = ~CLK;

  word_accumulator_if #(.WIDTH(W)) bus0 ();
  word_accumulator_if #(.WIDTH(W)) bus1 ();
  logic [15:0] cnt0, cnt1;

  word_accumulator #(.WIDTH(W), .COUNT(C0)) dut0 (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus0),
    .sums_count (cnt0)
  );

  word_accumulator #(.WIDTH(W), .COUNT(C1)) dut1 (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus1),
    .sums_count (cnt1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state, one entry per instance
  longint       true_sum [2];
  int           taken    [2];
  bit           pending  [2];
  logic [W-1:0] pend_sum [2];
  logic [15:0]  exp_cnt  [2];
  logic [W-1:0] last_sum [2];
  bit           last_took;

  int           idx;
  logic [W-1:0] gap_words [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int group_len(input int sel);
    return (sel == 0) ? C0 : C1;
  endfunction

  // Apply the compiled-in overflow rule to the exact arithmetic sum
  function automatic logic [W-1:0] fold(input longint s);
`ifdef WORD_ACCUMULATOR_SATURATE_EN
    longint max_v;
    max_v = (longint'(1) << W) - 1;
    return (s > max_v) ? '1 : s[W-1:0];
`else
    return s[W-1:0];
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      true_sum[s] = 0;
      taken[s]    = 0;
      pending[s]  = 1'b0;
      pend_sum[s] = '0;
      exp_cnt[s]  = '0;
    end
  endtask

  task automatic set_in(input int sel, input logic frdy, input logic [W-1:0] word,
                        input logic drdy, input logic erdy);
    if (sel == 0) begin
      bus0.in_first      = word;
      bus0.in_first__RDY = frdy;
      bus0.in_deq__RDY   = drdy;
      bus0.out_enq__RDY  = erdy;
    end else begin
      bus1.in_first      = word;
      bus1.in_first__RDY = frdy;
      bus1.in_deq__RDY   = drdy;
      bus1.out_enq__RDY  = erdy;
    end
  endtask

  // One clock cycle on one instance: drive its inputs just after the rising
  // edge, check it on the falling edge, then advance the model to the next edge.
  task automatic step(input int sel, input logic frdy, input logic [W-1:0] word,
                      input logic drdy, input logic erdy);
    logic         o_deq, o_ena, e_deq;
    logic [W-1:0] o_v, e_v;
    logic [15:0]  o_cnt;
    string        u;
    u = (sel == 0) ? "u0" : "u1";
    set_in(sel, frdy, word, drdy, erdy);
    @(negedge CLK);
    if (sel == 0) begin
      o_deq = bus0.in_deq__ENA; o_ena = bus0.out_enq__ENA; o_v = bus0.out_enq_v; o_cnt = cnt0;
    end else begin
      o_deq = bus1.in_deq__ENA; o_ena = bus1.out_enq__ENA; o_v = bus1.out_enq_v; o_cnt = cnt1;
    end
    e_deq = !pending[sel] && frdy && drdy;
    e_v   = pending[sel] ? pend_sum[sel] : '0;
    check({u, ".deq_ena"}, 64'(o_deq), 64'(e_deq));
    check({u, ".enq_ena"}, 64'(o_ena), 64'(pending[sel]));
    check({u, ".enq_v"}, 64'(o_v), 64'(e_v));
    check({u, ".sums_count"}, 64'(o_cnt), 64'(exp_cnt[sel]));
    last_took = e_deq;
    if (e_deq) begin
      true_sum[sel] += longint'(word);
      taken[sel]++;
      if (taken[sel] == group_len(sel)) begin
        pend_sum[sel] = fold(true_sum[sel]);
        pending[sel]  = 1'b1;
        true_sum[sel] = 0;
        taken[sel]    = 0;
      end
    end else if (pending[sel] && erdy) begin
      last_sum[sel] = o_v;
      pending[sel]  = 1'b0;
      exp_cnt[sel]  = exp_cnt[sel] + 16'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    gap_words = '{32'd7, 32'd8, 32'd9, 32'd10};
    set_in(0, 1'b0, '0, 1'b0, 1'b0);
    set_in(1, 1'b0, '0, 1'b0, 1'b0);
    model_reset();

    // Reset state, with both upstream RDYs high to show the dequeue is gated
    set_in(0, 1'b1, 32'h55, 1'b1, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    check("rst.u0.deq_ena", 64'(bus0.in_deq__ENA), 64'd0);
    check("rst.u0.enq_ena", 64'(bus0.out_enq__ENA), 64'd0);
    check("rst.u0.enq_v", 64'(bus0.out_enq_v), 64'd0);
    check("rst.u0.sums_count", 64'(cnt0), 64'd0);
    check("rst.u1.enq_ena", 64'(bus1.out_enq__ENA), 64'd0);
    check("rst.u1.sums_count", 64'(cnt1), 64'd0);
    set_in(0, 1'b0, '0, 1'b0, 1'b0);
    nRST = 1'b1;

    // Basic group: 1+2+3+4
    for (int i = 1; i <= 4; i++) step(0, 1'b1, W'(i), 1'b1, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("basic.sum", 64'(last_sum[0]), 64'd10);
    check("basic.sums_count", 64'(cnt0), 64'd1);

    // Backpressure: the held sum survives RDY low while upstream keeps offering
    for (int i = 0; i < 4; i++) step(0, 1'b1, 32'h10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 32'h99, 1'b1, 1'b0);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("bp.sum", 64'(last_sum[0]), 64'h40);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 32'd5, 1'b1, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("bp.next_sum", 64'(last_sum[0]), 64'd20);

    // Overflow: wrap or saturate depending on the build
    step(0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step(0, 1'b1, 32'd2, 1'b1, 1'b1);
    step(0, 1'b1, 32'd0, 1'b1, 1'b1);
    step(0, 1'b1, 32'd0, 1'b1, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("ovf.sum", 64'(last_sum[0]), 64'(OVF_SUM));

    // Upstream gaps: first__RDY toggles randomly while words 7..10 are offered
    idx = 0;
    for (int n = 0; n < 200 && idx < 4; n++) begin
      step(0, 1'($urandom_range(0, 1)), gap_words[idx], 1'b1, 1'b1);
      if (last_took) idx++;
    end
    check("gap.words_taken", 64'(idx), 64'd4);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("gap.sum", 64'(last_sum[0]), 64'd34);

    // Random words and handshakes on all three RDYs
    for (int n = 0; n < 120; n++) begin
      step(0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 2; n++) step(0, 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-group: two takes, then nRST drops between edges
    step(0, 1'b1, 32'd100, 1'b1, 1'b1);
    step(0, 1'b1, 32'd200, 1'b1, 1'b1);
    set_in(0, 1'b1, 32'd5, 1'b1, 1'b1);
    #2;
    check("amid.deq_ena_before", 64'(bus0.in_deq__ENA), 64'd1);
    nRST = 1'b0;
    #1;
    check("amid.deq_ena", 64'(bus0.in_deq__ENA), 64'd0);
    check("amid.enq_ena", 64'(bus0.out_enq__ENA), 64'd0);
    check("amid.enq_v", 64'(bus0.out_enq_v), 64'd0);
    check("amid.sums_count", 64'(cnt0), 64'd0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1'b1, 32'd1, 1'b1, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b1);
    check("amid.sum_after", 64'(last_sum[0]), 64'd4);

    // COUNT=1 with 65537 words of 3: each sum is 3 and the counter wraps to 1
    set_in(0, 1'b0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 2 * 65537; n++) step(1, 1'b1, 32'd3, 1'b1, 1'b1);
    check("c1.last_sum", 64'(last_sum[1]), 64'd3);
    check("c1.sums_wrap", 64'(cnt1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
